fm_feeder: RTL

Streaming source for the convolution `PE`. It holds one FM_SIZE×FM_SIZE feature map in a local buffer and a latched K×K weight vector. On `i_start` it drives the raster-ordered pixel stream, the weights and the enable into the PE's `i_DataFM` / `i_Weight` / `i_en` inputs. It keeps the enable high through a programmable drain window so the PE's internal pipeline and output counter complete, then pulses done.

---
 rtl/fm_pkg.sv | 23 ++
 rtl/fm_buffer.sv | 27 ++
 rtl/fm_feeder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fm_pkg.sv
// Shared types and sizing helpers for the PE feature-map feeder.
package fm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int A_WIDTH = 30;
    localparam int W_SLICE = 18;

    function automatic int pix_count(input int fm_size);
        return fm_size * fm_size;
    endfunction

    function automatic int addr_width(input int fm_size);
        return (fm_size * fm_size > 1) ? $clog2(fm_size * fm_size) : 1;
    endfunction

endpackage

// File: rtl/fm_buffer.sv
// Simple dual-port pixel store: synchronous write, registered read, no reset.
module fm_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        rd_data_q <= mem[i_rd_addr];
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/fm_feeder.sv
// Streams a buffered feature map plus latched weights into the convolution PE,
// holding enable through a drain window before pulsing done.
//
// state    | meaning
// S_IDLE   | accepts pixel writes, weight loads and start
// S_PRIME  | one cycle covering the buffer read latency
// S_STREAM | FM_SIZE^2 cycles, one pixel per cycle (outputs lag by one)
// S_DRAIN  | DRAIN_CYCLES cycles of enable with zero data
// S_DONE   | one cycle, done pulse follows
module fm_feeder
    import fm_pkg::*;
#(
    parameter int KERNEL_SIZE  = 2,
    parameter int FM_SIZE      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int SIGNED       = 1,
    parameter int DRAIN_CYCLES = 2,
    localparam int N  = pix_count(FM_SIZE),
    localparam int AW = addr_width(FM_SIZE),
    localparam int WW = KERNEL_SIZE * KERNEL_SIZE * W_SLICE
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [AW-1:0]              i_wr_addr,
    input  logic [DATA_WIDTH-1:0]      i_wr_data,
    input  logic                       i_wt_load,
    input  logic [WW-1:0]              i_wt_data,
    input  logic                       i_start,
    input  logic                       i_abort,
    output logic signed [A_WIDTH-1:0]  o_DataFM,
    output logic [WW-1:0]              o_Weight,
    output logic                       o_en,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int CNT_W = 16;
    localparam logic [A_WIDTH-1:0] EXT_MASK = ~({A_WIDTH{1'b1}} >> (A_WIDTH - DATA_WIDTH));

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]          rd_addr_q, rd_addr_d;
    logic [WW-1:0]          wt_q, wt_d;
    logic [A_WIDTH-1:0]     data_q, data_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [A_WIDTH-1:0]     pix_ext;
    logic                   ready;
    logic                   abort_hit;

    // The busy flop trails the state by a cycle after DONE; the block only
    // counts as idle once it has cleared, which sets the back-to-back spacing.
    assign ready     = (state_q == S_IDLE) && !busy_q;
    assign abort_hit = i_abort && ((state_q == S_PRIME) || (state_q == S_STREAM)
                                   || (state_q == S_DRAIN));

    fm_buffer #(
        .DEPTH (N),
        .AW    (AW),
        .DW    (DATA_WIDTH)
    ) u_buffer (
        .i_clk     (i_clk),
        .i_wr_en   (i_wr_en && ready),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_addr_q),
        .o_rd_data (rd_data)
    );

    always_comb begin
        pix_ext = A_WIDTH'(rd_data);
        if ((SIGNED != 0) && rd_data[DATA_WIDTH-1]) begin
            pix_ext = pix_ext | EXT_MASK;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        wt_d      = wt_q;

        if (ready && i_wt_load) begin
            wt_d = i_wt_data;
        end

        case (state_q)
            S_IDLE: begin
                if (ready && i_start) begin
                    state_d   = S_PRIME;
                    rd_addr_d = '0;
                end
            end
            S_PRIME: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_STREAM;
                    cnt_d     = CNT_W'(N - 1);
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            S_STREAM: begin
                if (rd_addr_q != AW'(N - 1)) begin
                    rd_addr_d = rd_addr_q + AW'(1);
                end
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the current state, so the visible stream lags
    // the STREAM state by one cycle and lines up with the buffer read data.
    always_comb begin
        en_d   = !abort_hit && ((state_q == S_STREAM) || (state_q == S_DRAIN));
        data_d = (!abort_hit && (state_q == S_STREAM)) ? pix_ext : '0;
        done_d = (state_q == S_DONE);
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            wt_q      <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            wt_q      <= wt_d;
            data_q    <= data_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_DataFM = data_q;
    assign o_Weight = wt_q;
    assign o_en     = en_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

endmodule
